// File: rtl/cache_fill_fsm.sv
// Cache miss handler: streams one 8-word block from main memory into the data array
// and writes the matching tag when the final word lands.
module cache_fill_fsm #(
   parameter int WORDS  = 8,
   parameter int BLOCKS = 128,
   parameter int TAG_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              miss_detected,
   input  logic [15:0]       miss_address,
   input  logic              memory_data_valid,
   input  logic [15:0]       memory_data,
   output logic              fsm_busy,
   output logic              mem_read,
   output logic [15:0]       memory_address,
   output logic              write_data_array,
   output logic [BLOCKS-1:0] block_enable,
   output logic [WORDS-1:0]  word_enable,
   output logic [15:0]       data_out,
   output logic              write_tag_array,
   output logic [TAG_W-1:0]  tag_out
);

   localparam int CNT_W = $clog2(WORDS) + 1;
   localparam int OFS_W = $clog2(WORDS) + 1;
   localparam int IDX_W = $clog2(BLOCKS);
   localparam logic [CNT_W-1:0] FULL = CNT_W'(WORDS);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);

   typedef enum logic {S_IDLE, S_FILL} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [15:0]      r_base;
   logic [15:0]      w_base_nxt;
   logic [CNT_W-1:0] r_issue_cnt;
   logic [CNT_W-1:0] w_issue_nxt;
   logic [CNT_W-1:0] r_recv_cnt;
   logic [CNT_W-1:0] w_recv_nxt;
   logic             w_unused_ofs;

   // The byte offset within a block never matters: fills always start at word 0.
   assign w_unused_ofs = ^miss_address[OFS_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_base      <= '0;
         r_issue_cnt <= '0;
         r_recv_cnt  <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_base      <= w_base_nxt;
         r_issue_cnt <= w_issue_nxt;
         r_recv_cnt  <= w_recv_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_base_nxt       = r_base;
      w_issue_nxt      = r_issue_cnt;
      w_recv_nxt       = r_recv_cnt;
      fsm_busy         = 1'b0;
      mem_read         = 1'b0;
      memory_address   = '0;
      write_data_array = 1'b0;
      block_enable     = '0;
      word_enable      = '0;
      write_tag_array  = 1'b0;
      tag_out          = '0;
      data_out         = memory_data;

      case (r_state)
         S_IDLE: begin
            // Stall in the miss cycle itself, but never while reset is held.
            fsm_busy = miss_detected & rst_n;
            if (miss_detected) begin
               w_state_nxt = S_FILL;
               w_base_nxt  = {miss_address[15:OFS_W], {OFS_W{1'b0}}};
               w_issue_nxt = '0;
               w_recv_nxt  = '0;
            end
         end

         S_FILL: begin
            fsm_busy       = 1'b1;
            block_enable   = BLOCKS'(1) << r_base[OFS_W +: IDX_W];
            tag_out        = r_base[15 -: TAG_W];
            memory_address = r_base + 16'({r_issue_cnt, 1'b0});
            if (r_issue_cnt < FULL) begin
               mem_read    = 1'b1;
               w_issue_nxt = r_issue_cnt + 1'b1;
            end
            // Returns are in order, so the receive count alone selects the word.
            if (r_recv_cnt < FULL) begin
               word_enable = WORDS'(1) << r_recv_cnt[CNT_W-2:0];
               if (memory_data_valid) begin
                  write_data_array = 1'b1;
                  w_recv_nxt       = r_recv_cnt + 1'b1;
                  if (r_recv_cnt == LAST) begin
                     write_tag_array = 1'b1;
                     w_state_nxt     = S_IDLE;
                  end
               end
            end
         end

         default: w_state_nxt = S_IDLE;
      endcase
   end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss handler that fills one 8-word cache block from multi-cycle main memory. It writes into the 128-block data array and the matching tag array. On a miss it streams 8 word reads to memory and writes each returned word into the data array using one-hot block and word enables. It pulses a tag-array write on the final word. It sits between the cache hit/miss logic and the memory model, and stalls the pipeline via fsm_busy.

Parameters:
WORDS, 8, words per block (one-hot word_enable width)
BLOCKS, 128, blocks in array (one-hot block_enable width)
TAG_W, 5, tag bits = miss_address[15:11]

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
miss_detected  in  1  cache miss this cycle; sampled only in IDLE
miss_address  in  16  byte address of missing access
memory_data_valid  in  1  memory_data carries the next in-order returned word
memory_data  in  16  word returned by memory
fsm_busy  out  1  fill in progress; pipeline must stall
mem_read  out  1  read request to memory this cycle
memory_address  out  16  word address of current request
write_data_array  out  1  data array write strobe
block_enable  out  128  one-hot block select (index = latched addr[10:4])
word_enable  out  8  one-hot word select (= receive count)
data_out  out  16  data to array; combinational pass-through of memory_data
write_tag_array  out  1  one-cycle tag write strobe
tag_out  out  5  latched miss_address[15:11]

Behaviour:
- Reset (async, rst_n=0): state IDLE; issue_cnt=0; recv_cnt=0; base=0. All outputs 0 except data_out, which follows memory_data.
- States: IDLE, FILL. Registers: base[15:0], issue_cnt[3:0] (0..8), recv_cnt[3:0] (0..8).
- IDLE:
  - fsm_busy = miss_detected (same-cycle stall). All other outputs 0.
  - On a clk edge with miss_detected=1: base <- {miss_address[15:4], 4'b0}; counters cleared; go to FILL.
- FILL, request side:
  - mem_read = (issue_cnt<8).
  - memory_address = base + 2*issue_cnt.
  - issue_cnt increments each cycle while <8, so requests go out on 8 consecutive cycles.
- FILL, return side:
  - write_data_array = memory_data_valid & (recv_cnt<8).
  - word_enable = one-hot(recv_cnt[2:0]) when recv_cnt<8, else 0.
  - recv_cnt increments on each accepted valid.
  - Words arrive in order; memory latency is arbitrary and may overlap the issue phase.
- FILL, block/tag outputs: block_enable = one-hot(base[10:4]), held constant for the whole fill. tag_out = base[15:11].
- Final word: on the cycle the 8th word is accepted (recv_cnt==7 & memory_data_valid):
  - write_data_array=1 and write_tag_array=1 in the same cycle.
  - Next edge: go to IDLE.
- fsm_busy = 1 throughout FILL, including the final write cycle. It deasserts the cycle after.
- Ignored inputs:
  - miss_detected while in FILL.
  - memory_data_valid in IDLE or after 8 words accepted.
  - miss_address after capture.
- Back-to-back: a miss asserted in the first IDLE cycle after a fill starts a new fill. There is no dead cycle beyond that IDLE cycle.
- Reset mid-fill: abort immediately. No further writes; no tag write.
- One-hot invariant: block_enable and word_enable are either all-zero or have exactly one bit set, never more.

Test Plan:
- Basic fill: miss at 0x1234, memory valid 4 cycles after each request. Required response:
  - fsm_busy=1 in the miss cycle; mem_read on cycles 1–8 with addresses 0x1230, 0x1232, …, 0x123E.
  - Writes on cycles 5–12 with word_enable 0x01, 0x02, …, 0x80 and block_enable bit 35 only.
  - write_tag_array only on cycle 12, tag_out=0x02; IDLE and fsm_busy=0 on cycle 13.
- Data integrity: memory returns 0xA000+k for word k. Each write cycle must show data_out=0xA000+k with word_enable bit k; read back the array to confirm.
- Stalled memory: insert 3-cycle gaps between valids. Required response:
  - No writes on gap cycles; recv_cnt holds.
  - Fill completes after exactly 8 valids; tag write coincides with the 8th.
- Spurious inputs:
  - miss_detected pulse mid-fill at 0x0F00: no effect on base or counters.
  - valid pulse while IDLE: write_data_array stays 0.
  - 9th valid after completion: ignored.
- Reset mid-fill: deassert rst_n after 3 accepted words. Required response:
  - All outputs 0 asynchronously; no tag write.
  - A new miss at 0xFFFE then fills index 127, tag 0x1F, addresses 0xFFF0–0xFFFE.
- Back-to-back misses: a second miss at 0x0010 in the IDLE cycle after the first fill. The new fill starts with block_enable bit 1 and address 0x0010.
